// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared types and constants for the decode-control stage.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package decode_ctrl_pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2
  } dec_state_e;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU
  } alu_op_e;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic PCtoReg;
  } WB_ctrl;

  // CS is the active-low memory chip select.
  typedef struct packed {
    logic MemRead;
    logic CS;
    logic branch;
    logic jump;
    logic AddtoPC;
  } M_ctrl;

  // ALUsrc: 00 register, 10 immediate, 11 PC-relative.
  typedef struct packed {
    alu_op_e    ALUop;
    logic [1:0] ALUsrc;
    logic       branch;
  } EX_ctrl;

  localparam WB_ctrl WB_DEFAULT = '{RegWrite: 1'b0, MemtoReg: 1'b0, PCtoReg: 1'b0};
  localparam M_ctrl  M_DEFAULT  = '{MemRead: 1'b0, CS: 1'b1, branch: 1'b0,
                                    jump: 1'b0, AddtoPC: 1'b0};
  localparam EX_ctrl EX_DEFAULT = '{ALUop: ALU_NOP, ALUsrc: 2'b00, branch: 1'b0};

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  // Integer ALU op from funct3; alt selects SUB for 000 and SRA for 101.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_decode_comb.sv
// Pure RV32I(+M) decoder: instruction word to control bundles and trap class.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing stage owns all handshaking.
module decode_ctrl_pipe_decode_comb
  import decode_ctrl_pipe_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b0
) (
  input  logic [31:0] instr,
  output WB_ctrl      wb,
  output M_ctrl       m,
  output EX_ctrl      ex,
  output logic        md_valid,
  output logic [2:0]  md_op,
  output logic        is_illegal,
  output logic        is_ecall,
  output logic        is_ebreak,
  output logic        is_mret
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode table with strict funct7 checks; illegal words leave bundles at don't-care defaults.
  always_comb begin
    wb         = WB_DEFAULT;
    m          = M_DEFAULT;
    ex         = EX_DEFAULT;
    md_valid   = 1'b0;
    md_op      = 3'b000;
    is_illegal = 1'b0;
    is_ecall   = 1'b0;
    is_ebreak  = 1'b0;
    is_mret    = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ex.ALUsrc   = 2'b10;
        ex.ALUop    = ALU_ADD;
        wb.RegWrite = 1'b1;
        wb.MemtoReg = 1'b1;
        m.MemRead   = 1'b1;
        m.CS        = 1'b0;
      end
      OPC_OPIMM: begin
        ex.ALUsrc   = 2'b10;
        wb.RegWrite = 1'b1;
        // Immediate ADD has no SUB form, so alt only matters for shifts.
        ex.ALUop    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          is_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
          is_illegal = 1'b1;
      end
      OPC_AUIPC: begin
        ex.ALUsrc   = 2'b11;
        ex.ALUop    = ALU_ADD;
        wb.RegWrite = 1'b1;
      end
      OPC_STORE: begin
        ex.ALUsrc = 2'b10;
        ex.ALUop  = ALU_ADD;
        m.CS      = 1'b0;
      end
      OPC_OP: begin
        wb.RegWrite = 1'b1;
        if (funct7 == F7_BASE) begin
          ex.ALUop = alu_from_f3(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ex.ALUop = alu_from_f3(funct3, 1'b1);
        end else if (funct7 == F7_MULDIV && EN_M_EXT) begin
          md_valid = 1'b1;
          md_op    = funct3;
        end else begin
          is_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        ex.ALUsrc   = 2'b10;
        ex.ALUop    = ALU_ADD;
        wb.RegWrite = 1'b1;
        m.CS        = 1'b0;
        m.MemRead   = 1'b1;
      end
      OPC_BRANCH: begin
        m.branch  = 1'b1;
        ex.branch = 1'b1;
        case (funct3)
          3'b000:  ex.ALUop = ALU_BEQ;
          3'b001:  ex.ALUop = ALU_BNE;
          3'b100:  ex.ALUop = ALU_BLT;
          3'b101:  ex.ALUop = ALU_BGE;
          3'b110:  ex.ALUop = ALU_BLTU;
          3'b111:  ex.ALUop = ALU_BGEU;
          default: is_illegal = 1'b1;
        endcase
      end
      OPC_JALR: begin
        m.jump      = 1'b1;
        m.AddtoPC   = 1'b1;
        ex.ALUsrc   = 2'b10;
        ex.ALUop    = ALU_ADD;
        wb.RegWrite = 1'b1;
        wb.PCtoReg  = 1'b1;
      end
      OPC_JAL: begin
        m.jump      = 1'b1;
        ex.ALUsrc   = 2'b11;
        ex.ALUop    = ALU_ADD;
        wb.RegWrite = 1'b1;
        wb.PCtoReg  = 1'b1;
      end
      OPC_SYSTEM: begin
        // Only the three exact encodings are supported; no CSR access here.
        if (instr == INSTR_ECALL)       is_ecall   = 1'b1;
        else if (instr == INSTR_EBREAK) is_ebreak  = 1'b1;
        else if (instr == INSTR_MRET)   is_mret    = 1'b1;
        else                            is_illegal = 1'b1;
      end
      default: begin
        // The all-zero word is a pipeline bubble, not an illegal opcode.
        if (instr != 32'h0) is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode stage: one-entry output register, trap/MRET request FSM, illegal counter.
// Latency: one cycle from accept to decoded bundle on the outputs.
// Backpressure: instr_ready drops while the held entry is not drained, a trap/MRET is pending, or flush is high.
module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output WB_ctrl           WB,
  output M_ctrl            M,
  output EX_ctrl           EX,
  output logic             md_valid,
  output logic [2:0]       md_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             trap_req,
  output logic [3:0]       trap_cause,
  output logic             mret_req,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_state_e state, state_nxt;

  WB_ctrl     d_wb;
  M_ctrl      d_m;
  EX_ctrl     d_ex;
  logic       d_md_valid;
  logic [2:0] d_md_op;
  logic       d_illegal, d_ecall, d_ebreak, d_mret;

  logic accept, raise_trap, enter_mret, load;

  decode_ctrl_pipe_decode_comb #(
    .EN_M_EXT (EN_M_EXT)
  ) u_dec (
    .instr      (instr),
    .wb         (d_wb),
    .m          (d_m),
    .ex         (d_ex),
    .md_valid   (d_md_valid),
    .md_op      (d_md_op),
    .is_illegal (d_illegal),
    .is_ecall   (d_ecall),
    .is_ebreak  (d_ebreak),
    .is_mret    (d_mret)
  );

  assign accept     = instr_valid && instr_ready;
  assign raise_trap = accept && (d_illegal || d_ecall || d_ebreak);
  assign enter_mret = accept && d_mret;
  assign load       = accept && !(d_illegal || d_ecall || d_ebreak || d_mret);

  // FSM state register; reset aborts any pending trap or MRET.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: flush dominates, ack releases, system/illegal accepts enter a pending state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (raise_trap)      state_nxt = TRAP;
          else if (enter_mret) state_nxt = MRET;
        end
        TRAP, MRET: begin
          if (trap_ack) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM outputs: the request lines are decoded straight from the registered state.
  always_comb begin
    instr_ready = (state == RUN) && (!out_valid || out_ready) && !flush;
    trap_req    = (state == TRAP);
    mret_req    = (state == MRET);
  end

  // Output register: load on a legal accept, otherwise drain; flush only kills the valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      WB        <= WB_DEFAULT;
      M         <= M_DEFAULT;
      EX        <= EX_DEFAULT;
      md_valid  <= 1'b0;
      md_op     <= 3'b000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      WB        <= d_wb;
      M         <= d_m;
      EX        <= d_ex;
      md_valid  <= d_md_valid;
      md_op     <= d_md_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Trap cause latches with the trap; it is left in place after ack or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_cause <= 4'd0;
    end else if (raise_trap) begin
      if (d_illegal)     trap_cause <= CAUSE_ILLEGAL;
      else if (d_ebreak) trap_cause <= CAUSE_EBREAK;
      else               trap_cause <= CAUSE_ECALL;
    end
  end

  // Saturating count of accepted illegal instructions; flushed offers never reach accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && d_illegal && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;
  import decode_ctrl_pipe_pkg::*;

  localparam int K_OK = 0, K_ILL = 1, K_ECALL = 2, K_EBREAK = 3, K_MRET = 4;

  typedef struct {
    int         kind;
    WB_ctrl     wb;
    M_ctrl      m;
    EX_ctrl     ex;
    bit         mdv;
    logic [2:0] mdop;
  } exp_t;

  logic        clk;
  logic        rst_n, flush, instr_valid, out_ready, trap_ack;
  logic [31:0] instr;

  WB_ctrl     wb0, wb1;
  M_ctrl      m0, m1;
  EX_ctrl     ex0, ex1;
  logic       mdv0, mdv1, ov0, ov1, ir0, ir1, tr0, tr1, mr0, mr1;
  logic [2:0] mdop0, mdop1;
  logic [3:0] tc0, tc1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;

  decode_ctrl_pipe #(.EN_M_EXT(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .instr_ready(ir0), .WB(wb0), .M(m0), .EX(ex0),
    .md_valid(mdv0), .md_op(mdop0), .out_valid(ov0), .out_ready(out_ready),
    .trap_req(tr0), .trap_cause(tc0), .mret_req(mr0), .trap_ack(trap_ack),
    .illegal_cnt(cnt0)
  );

  decode_ctrl_pipe #(.EN_M_EXT(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .instr_ready(ir1), .WB(wb1), .M(m1), .EX(ex1),
    .md_valid(mdv1), .md_op(mdop1), .out_valid(ov1), .out_ready(out_ready),
    .trap_req(tr1), .trap_cause(tc1), .mret_req(mr1), .trap_ack(trap_ack),
    .illegal_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference decode from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] w, input bit en_m);
    exp_t       e;
    alu_op_e    arith [8];
    alu_op_e    brop  [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    brop  = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e.kind = K_OK;
    e.wb = '0;
    e.m = '0;  e.m.CS = 1'b1;
    e.ex.ALUop = ALU_NOP; e.ex.ALUsrc = 2'b00; e.ex.branch = 1'b0;
    e.mdv = 1'b0; e.mdop = 3'b000;
    if (w == 32'h0000_0073)      e.kind = K_ECALL;
    else if (w == 32'h0010_0073) e.kind = K_EBREAK;
    else if (w == 32'h3020_0073) e.kind = K_MRET;
    else if (w == 32'h0) begin end
    else begin
      case (op)
        7'h03: begin e.ex.ALUsrc = 2; e.ex.ALUop = ALU_ADD; e.wb.RegWrite = 1; e.wb.MemtoReg = 1; e.m.MemRead = 1; e.m.CS = 0; end
        7'h13: begin
          e.ex.ALUsrc = 2; e.wb.RegWrite = 1; e.ex.ALUop = arith[f3];
          if (f3 == 3'd5 && f7 == 7'h20) e.ex.ALUop = ALU_SRA;
          if ((f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && f7 != 0 && f7 != 7'h20)) e.kind = K_ILL;
        end
        7'h17: begin e.ex.ALUsrc = 3; e.ex.ALUop = ALU_ADD; e.wb.RegWrite = 1; end
        7'h23: begin e.ex.ALUsrc = 2; e.ex.ALUop = ALU_ADD; e.m.CS = 0; end
        7'h33: begin
          e.wb.RegWrite = 1;
          if (f7 == 0)                      e.ex.ALUop = arith[f3];
          else if (f7 == 7'h20 && f3 == 0)  e.ex.ALUop = ALU_SUB;
          else if (f7 == 7'h20 && f3 == 5)  e.ex.ALUop = ALU_SRA;
          else if (f7 == 7'h01 && en_m) begin e.mdv = 1; e.mdop = f3; end
          else e.kind = K_ILL;
        end
        7'h37: begin e.ex.ALUsrc = 2; e.ex.ALUop = ALU_ADD; e.wb.RegWrite = 1; e.m.CS = 0; e.m.MemRead = 1; end
        7'h63: begin
          e.m.branch = 1; e.ex.branch = 1; e.ex.ALUop = brop[f3];
          if (f3 == 3'd2 || f3 == 3'd3) e.kind = K_ILL;
        end
        7'h67: begin e.m.jump = 1; e.m.AddtoPC = 1; e.ex.ALUsrc = 2; e.ex.ALUop = ALU_ADD; e.wb.RegWrite = 1; e.wb.PCtoReg = 1; end
        7'h6f: begin e.m.jump = 1; e.ex.ALUsrc = 3; e.ex.ALUop = ALU_ADD; e.wb.RegWrite = 1; e.wb.PCtoReg = 1; end
        default: e.kind = K_ILL;
      endcase
    end
    return e;
  endfunction

  // Behavioural model: pend 0 = free, 1 = trap waiting, 2 = mret waiting.
  bit         en_m [2] = '{1'b0, 1'b1};
  int         cmax [2] = '{255, 3};
  bit         model_ok = 1'b0;
  int         pend [2];
  bit         mov  [2];
  WB_ctrl     mwb  [2];
  M_ctrl      mm   [2];
  EX_ctrl     mex  [2];
  bit         mmdv [2];
  logic [2:0] mmdop[2];
  logic [3:0] mcause[2];
  int         mcnt [2];
  bit         m_rdy, m_acc;
  exp_t       m_e;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = 0; mov[k] = 0; mcause[k] = 0; mcnt[k] = 0;
        mwb[k] = '0; mm[k] = '0; mm[k].CS = 1'b1;
        mex[k].ALUop = ALU_NOP; mex[k].ALUsrc = 2'b00; mex[k].branch = 1'b0;
        mmdv[k] = 0; mmdop[k] = 0;
        model_ok = 1'b1;
      end else begin
        m_rdy = (pend[k] == 0) && (!mov[k] || out_ready) && !flush;
        m_acc = instr_valid && m_rdy;
        m_e   = ref_decode(instr, en_m[k]);
        if (flush) begin
          mov[k] = 0; pend[k] = 0;
        end else begin
          if (pend[k] != 0 && trap_ack) pend[k] = 0;
          if (m_acc && m_e.kind == K_OK) begin
            mov[k] = 1; mwb[k] = m_e.wb; mm[k] = m_e.m; mex[k] = m_e.ex;
            mmdv[k] = m_e.mdv; mmdop[k] = m_e.mdop;
          end else if (out_ready) begin
            mov[k] = 0;
          end
          if (m_acc) begin
            case (m_e.kind)
              K_ILL:    begin pend[k] = 1; mcause[k] = 4'd2; if (mcnt[k] < cmax[k]) mcnt[k]++; end
              K_ECALL:  begin pend[k] = 1; mcause[k] = 4'd11; end
              K_EBREAK: begin pend[k] = 1; mcause[k] = 4'd3; end
              K_MRET:   pend[k] = 2;
              default:  begin end
            endcase
          end
        end
      end
    end
  end

  // Per-instance views of the DUT outputs.
  WB_ctrl     a_wb [2];
  M_ctrl      a_m  [2];
  EX_ctrl     a_ex [2];
  logic       a_mdv[2], a_ov[2], a_ir[2], a_tr[2], a_mr[2];
  logic [2:0] a_mdop[2];
  logic [3:0] a_tc [2];
  logic [7:0] a_cnt[2];
  assign a_wb[0] = wb0;   assign a_wb[1] = wb1;
  assign a_m[0]  = m0;    assign a_m[1]  = m1;
  assign a_ex[0] = ex0;   assign a_ex[1] = ex1;
  assign a_mdv[0] = mdv0; assign a_mdv[1] = mdv1;
  assign a_mdop[0] = mdop0; assign a_mdop[1] = mdop1;
  assign a_ov[0] = ov0;   assign a_ov[1] = ov1;
  assign a_ir[0] = ir0;   assign a_ir[1] = ir1;
  assign a_tr[0] = tr0;   assign a_tr[1] = tr1;
  assign a_mr[0] = mr0;   assign a_mr[1] = mr1;
  assign a_tc[0] = tc0;   assign a_tc[1] = tc1;
  assign a_cnt[0] = cnt0; assign a_cnt[1] = {6'd0, cnt1};

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("out_valid[%0d]", k), a_ov[k], mov[k]);
        chk($sformatf("instr_ready[%0d]", k), a_ir[k],
            (pend[k] == 0) && (!mov[k] || out_ready) && !flush);
        chk($sformatf("trap_req[%0d]", k), a_tr[k], pend[k] == 1);
        chk($sformatf("mret_req[%0d]", k), a_mr[k], pend[k] == 2);
        chk($sformatf("trap_cause[%0d]", k), a_tc[k], mcause[k]);
        chk($sformatf("illegal_cnt[%0d]", k), a_cnt[k], mcnt[k]);
        chk($sformatf("WB[%0d]", k), a_wb[k], mwb[k]);
        chk($sformatf("M[%0d]", k), a_m[k], mm[k]);
        chk($sformatf("EX[%0d]", k), a_ex[k], mex[k]);
        chk($sformatf("ex_branch_eq_m[%0d]", k), a_ex[k].branch, a_m[k].branch);
        chk($sformatf("md_valid[%0d]", k), a_mdv[k], mmdv[k]);
        chk($sformatf("md_op[%0d]", k), a_mdop[k], mmdop[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] w;
    int          sel, v;
    opcs = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
    sel = $urandom_range(0, 19);
    w = $urandom;
    if (sel < 13) begin
      w[6:0] = opcs[sel % 10];
      v = $urandom_range(0, 3);
      if (v == 0)      w[31:25] = 7'h00;
      else if (v == 1) w[31:25] = 7'h20;
      else if (v == 2) w[31:25] = 7'h01;
    end else if (sel == 13) w = 32'h0;
    else if (sel == 14) w = 32'h0000_0073;
    else if (sel == 15) w = 32'h0010_0073;
    else if (sel == 16) w = 32'h3020_0073;
    else if (sel == 17) w = 32'h0220_81B3;
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; out_ready = 1'b0;
    trap_ack = 1'b0; instr = 32'h0;
    step(); step();
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", ov0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_aluop", ex0.ALUop, ALU_NOP);
    chk("rst_cs", m0.CS, 1);
    chk("rst_trap", tr0, 0);

    // addi x1, x0, 5
    instr = 32'h0050_0093; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", ov0, 1);
    chk("addi_regwrite", wb0.RegWrite, 1);
    chk("addi_alusrc", ex0.ALUsrc, 2'b10);
    chk("addi_aluop", ex0.ALUop, ALU_ADD);
    chk("addi_cs", m0.CS, 1);
    step();

    // Two offers against a stalled consumer.
    out_ready = 1'b0; instr_valid = 1'b1; instr = 32'h00A0_0113;
    step(); instr = 32'h0000_10B7;
    step();
    @(negedge clk);
    chk("hold_valid", ov0, 1);
    chk("hold_ready", ir0, 0);
    chk("hold_memread", m0.MemRead, 0);
    step();
    @(negedge clk);
    chk("hold_stable_memread", m0.MemRead, 0);
    chk("hold_stable_alusrc", ex0.ALUsrc, 2'b10);
    step(); out_ready = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("lui_memread", m0.MemRead, 1);
    chk("lui_cs", m0.CS, 0);
    chk("lui_valid", ov0, 1);
    step();

    // Illegal word.
    instr = 32'hFFFF_FFFF; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("ill_trap", tr0, 1);
    chk("ill_cause", tc0, 2);
    chk("ill_cnt", cnt0, 1);
    chk("ill_ready", ir0, 0);
    chk("ill_no_load", ov0, 0);
    step();
    @(negedge clk);
    chk("ill_ready_wait", ir0, 0);
    step(); trap_ack = 1'b1;
    step(); trap_ack = 1'b0;
    @(negedge clk);
    chk("ack_trap_clr", tr0, 0);
    chk("ack_ready", ir0, 1);

    // mul x3, x1, x2 with and without the M extension.
    instr = 32'h0220_81B3; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("mul_noM_trap", tr0, 1);
    chk("mul_noM_cause", tc0, 2);
    chk("mul_M_mdv", mdv1, 1);
    chk("mul_M_mdop", mdop1, 0);
    chk("mul_M_rw", wb1.RegWrite, 1);
    chk("mul_M_notrap", tr1, 0);
    step(); trap_ack = 1'b1;
    step(); trap_ack = 1'b0;

    // MRET then flush, then ECALL.
    instr = 32'h3020_0073; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("mret_req", mr0, 1);
    chk("mret_no_valid", ov0, 0);
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    chk("flush_mret_clr", mr0, 0);
    chk("flush_ready", ir0, 1);
    instr = 32'h0000_0073; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    @(negedge clk);
    chk("ecall_cause", tc0, 11);
    chk("ecall_cnt", cnt0, 2);
    step(); trap_ack = 1'b1;
    step(); trap_ack = 1'b0;

    // Five more illegals: narrow counter saturates.
    for (int i = 0; i < 5; i++) begin
      instr = 32'hFFFF_FFFF; instr_valid = 1'b1;
      step(); instr_valid = 1'b0; trap_ack = 1'b1;
      step(); trap_ack = 1'b0;
    end
    @(negedge clk);
    chk("sat_cnt_narrow", cnt1, 3);
    chk("cnt_wide", cnt0, 7);

    // Flush beats a simultaneous illegal offer.
    step(); instr_valid = 1'b1; flush = 1'b1;
    step(); instr_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_trap", tr0, 0);
    chk("flush_drop_cnt", cnt0, 7);

    // Reset while trapped.
    instr_valid = 1'b1;
    step(); instr_valid = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_trap_req", tr0, 0);
    chk("rst_trap_cause", tc0, 0);
    chk("rst_trap_cnt", cnt0, 0);
    chk("rst_trap_ready", ir0, 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_n       = ($urandom_range(0, 299) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      instr_valid = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      trap_ack    = ($urandom_range(0, 9) < 3);
      instr       = rand_instr();
    end
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered, parametrised decode-control stage sitting between the IF/ID register and the ID/EX register.
- Decodes a 32-bit RV32I instruction, plus optional RV32M, into the existing WB/M/EX control bundles. The result is held in a one-entry output register with valid/ready handshakes on both sides.
- Adds strict funct7 legality checks and ECALL/EBREAK/MRET handling through a trap-request FSM. Adds a saturating illegal-instruction counter.

Parameters:
- EN_M_EXT, 0, 1 = decode RV32M (opcode 0110011, funct7 0000001); 0 = treat RV32M as illegal.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  kill the held output and any pending trap
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  stage can accept
- WB  out  WB_ctrl  registered write-back controls
- M  out  M_ctrl  registered memory controls
- EX  out  EX_ctrl  registered execute controls; EX.branch equals M.branch
- md_valid  out  1  registered; instruction is a RV32M op
- md_op  out  3  registered; RV32M funct3
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  downstream consumes
- trap_req  out  1  exception pending
- trap_cause  out  4  mcause code: 2 illegal, 3 ebreak, 11 ecall
- mret_req  out  1  MRET pending
- trap_ack  in  1  trap/MRET taken by the trap unit
- illegal_cnt  out  CNT_W  saturating count of illegal instructions

Behaviour:
- Reset, rst_n=0 at a clk edge:
  - out_valid=0, trap_req=0, mret_req=0, trap_cause=0, illegal_cnt=0, md_valid=0, md_op=0.
  - Bundles take their defaults: ALUop=ALU_NOP, ALUsrc=00, CS=1, all other fields 0.
  - FSM enters RUN.
  - Reset mid-trap aborts the trap.
- FSM states: RUN, TRAP, MRET.
  - instr_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
  - Accept = instr_valid && instr_ready. Latency is one cycle: the bundle is visible the cycle after accept.
- Output register:
  - Loads on accept of a legal non-system instruction and sets out_valid=1.
  - On out_ready && out_valid with no new load, out_valid goes to 0.
  - With out_ready=0, all outputs stay stable.
- Decode table (defaults as in reset):
  - Load 0000011: ALUsrc=10, ALU_ADD, RegWrite, MemtoReg, MemRead, CS=0.
  - OP-IMM 0010011: ALUsrc=10, RegWrite; funct3 selects ADD/AND/OR/XOR/SLT/SLTU/SLL/SRL-SRA.
    - funct3=001 requires funct7=0000000.
    - funct3=101 requires funct7 of 0000000 or 0100000.
  - AUIPC 0010111: ALUsrc=11, ALU_ADD, RegWrite.
  - Store 0100011: ALUsrc=10, ALU_ADD, CS=0.
  - OP 0110011:
    - funct7=0000000: normal op.
    - funct7=0100000: only funct3 000 (SUB) or 101 (SRA).
    - funct7=0000001: RV32M op when EN_M_EXT=1, giving RegWrite=1, ALU_NOP, md_valid=1, md_op=funct3.
    - Anything else is illegal.
  - LUI 0110111: ALUsrc=10, ALU_ADD, RegWrite, CS=0, MemRead=1.
  - Branch 1100011: branch=1; funct3 selects BEQ/BNE/BLT/BGE/BLTU/BGEU; 010 and 011 are illegal.
  - JALR 1100111: jump, ALUsrc=10, ALU_ADD, RegWrite, PCtoReg, AddtoPC.
  - JAL 1101111: jump, ALUsrc=11, ALU_ADD, RegWrite, PCtoReg.
  - All-zero instruction word: loaded as a bubble with defaults and out_valid=1.
  - SYSTEM 1110011, exact match only: 0x00000073 ECALL, 0x00100073 EBREAK, 0x30200073 MRET. Everything else is illegal.
  - Any other opcode is illegal.
- Illegal, ECALL or EBREAK accepted:
  - Output register is not loaded.
  - trap_req=1 and trap_cause are registered the next cycle.
  - FSM goes to TRAP.
  - Illegal only: illegal_cnt increments, saturating at all-ones.
- MRET accepted: mret_req=1 next cycle; FSM goes to MRET.
- TRAP or MRET with trap_ack=1: the req output is cleared next cycle and the FSM returns to RUN. No instruction is accepted in the cycle trap_ack is seen.
- While in TRAP or MRET, an already-held output may still drain via out_ready.
- flush=1:
  - Next cycle out_valid=0, trap_req=0, mret_req=0, FSM=RUN.
  - Flush wins over a simultaneous accept; that instruction is dropped and not counted.
  - illegal_cnt is unaffected.
- trap_ack in RUN is ignored.

Decomposition:
- my_pkg additions:
  - typedef dec_state_e {RUN, TRAP, MRET}.
  - Constants CAUSE_ILLEGAL=4'd2, CAUSE_EBREAK=4'd3, CAUSE_ECALL=4'd11.
  - Opcode localparams OPC_LOAD … OPC_SYSTEM.
  - Instruction constants INSTR_ECALL, INSTR_EBREAK, INSTR_MRET.
- Sub-module decode_comb: purely combinational; instr in, bundles plus md_valid/md_op/is_illegal/is_ecall/is_ebreak/is_mret out.
- decode_ctrl_pipe holds the register, FSM and counter.

Test Plan:
- 0x00500093 (addi) with out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUsrc=10, ALUop=ALU_ADD, CS=1.
- Two instructions with out_ready=0 -> first held stable, instr_ready=0. Raising out_ready -> second loads the following cycle.
- 0xFFFFFFFF -> trap_req=1, trap_cause=2, illegal_cnt=1, instr_ready=0 until trap_ack; back in RUN the cycle after ack.
- 0x022081B3 (mul): EN_M_EXT=0 -> trap_cause=2. EN_M_EXT=1 -> md_valid=1, md_op=000, RegWrite=1.
- 0x30200073 (MRET) -> mret_req=1, out_valid=0. flush next cycle -> mret_req=0, FSM=RUN. 0x00000073 -> trap_cause=11.
- CNT_W=2 with 5 illegal instructions each acked -> illegal_cnt=3. rst_n=0 during TRAP -> all outputs at reset values next cycle.
